// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the ROM combinationally and feeds a 2-entry prefetch queue.
// Optional build macro IFETCH_NOP_SQUASH_EN drops all-zero (nop) words instead of enqueueing them.
module instr_fetch_ctrl #(
    parameter int N        = 32,
    parameter int DEPTH    = 32,
    parameter int RESET_PC = 0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] rom_addr,
    input  logic [N-1:0] rom_instr,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_instr,
    output logic [N-1:0] out_pc,
    output logic         halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [N-1:0] DEPTH_W    = N'(DEPTH);
    localparam logic [N-1:0] RESET_PC_W = N'(RESET_PC);

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [1:0]   count_q, count_d;
    logic [N-1:0] head_instr_q, head_instr_d;
    logic [N-1:0] head_pc_q, head_pc_d;
    logic [N-1:0] tail_instr_q, tail_instr_d;
    logic [N-1:0] tail_pc_q, tail_pc_d;

    logic         pop;
    logic         fetch;
    logic         keep_word;
    logic         enq;
    logic [N-1:0] pc_plus1;
    logic [1:0]   cnt;

    assign rom_addr  = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_instr = head_instr_q;
    assign out_pc    = head_pc_q;
    assign halted    = (state_q == HALT);

    assign pop      = out_valid && out_ready;
    assign fetch    = (state_q == RUN) && ((count_q != 2'd2) || pop);
    assign pc_plus1 = pc_q + N'(1);

`ifdef IFETCH_NOP_SQUASH_EN
    assign keep_word = (rom_instr != '0);
`else
    assign keep_word = 1'b1;
`endif

    assign enq = fetch && keep_word;

    // Redirect overrides everything; otherwise pop shifts the tail forward before the new word lands.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        cnt          = count_q;

        if (redirect_valid) begin
            count_d = 2'd0;
            pc_d    = redirect_pc;
            state_d = (redirect_pc < DEPTH_W) ? RUN : HALT;
        end else begin
            if (pop) begin
                head_instr_d = tail_instr_q;
                head_pc_d    = tail_pc_q;
                cnt          = cnt - 2'd1;
            end
            if (enq) begin
                if (cnt == 2'd0) begin
                    head_instr_d = rom_instr;
                    head_pc_d    = pc_q;
                end else begin
                    tail_instr_d = rom_instr;
                    tail_pc_d    = pc_q;
                end
                cnt = cnt + 2'd1;
            end
            count_d = cnt;
            if (fetch) begin
                pc_d = pc_plus1;
                if (pc_plus1 == DEPTH_W) begin
                    state_d = HALT;
                end
            end
            if (state_q == BOOT) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC_W;
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: expected {pc, instr} pairs are queued per phase and
// popped on every accepted handshake; timing and halting points are checked directly.
module tb_instr_fetch_ctrl;

    localparam int N     = 32;
    localparam int DEPTH = 32;

    logic         clk;
    logic         rst;
    logic [N-1:0] romAddr;
    logic [N-1:0] romInstr;
    logic         redirectValid;
    logic [N-1:0] redirectPc;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] outInstr;
    logic [N-1:0] outPc;
    logic         halted;
    logic         romZero;

    int checkCount = 0;
    int passCount  = 0;
    int cyc;
    logic [63:0] expQ[$];

    instr_fetch_ctrl #(.N(N), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (romAddr),
        .rom_instr      (romInstr),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_instr      (outInstr),
        .out_pc         (outPc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench ROM: word k holds 0x1000_0000 + k, optionally word 0 forced to a nop.
    always_comb begin
        romInstr = '0;
        if (romAddr < DEPTH) begin
            romInstr = 32'h1000_0000 + romAddr;
            if (romZero && romAddr == 0) begin
                romInstr = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic redir, input logic [N-1:0] rpc);
        outReady      = ready;
        redirectValid = redir;
        redirectPc    = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushEntry(input logic [31:0] pc, input logic [31:0] instr);
        expQ.push_back({pc, instr});
    endtask

    task automatic pushRange(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            pushEntry(32'(first + i), 32'h1000_0000 + 32'(first + i));
        end
    endtask

    // Accept n items, comparing each against the scoreboard; returns cycles spent.
    task automatic drainExpect(input int n, input int maxCycles, output int cycles);
        int got;
        logic [63:0] e;
        got    = 0;
        cycles = 0;
        while (got < n && cycles < maxCycles) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("sbUnexpected", outPc, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outPc", outPc, e[63:32]);
                    checkOutput("outInstr", outInstr, e[31:0]);
                end
                got++;
            end
            step();
            cycles++;
        end
        if (got < n) begin
            checkOutput("drainTimeout", 32'(got), 32'(n));
        end
    endtask

    initial begin
        romZero = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        rst = 1'b1;

        // Reset values and boot timing
        #2;
        checkOutput("rstValid", {31'b0, outValid}, 32'd0);
        checkOutput("rstHalted", {31'b0, halted}, 32'd0);
        checkOutput("rstRomAddr", romAddr, 32'd0);
        checkOutput("rstOutPc", outPc, 32'd0);
        checkOutput("rstOutInstr", outInstr, 32'd0);
        step();
        rst = 1'b0;
        step();
        checkOutput("bootNoValid", {31'b0, outValid}, 32'd0);
        step();
        checkOutput("firstValid", {31'b0, outValid}, 32'd1);
        checkOutput("firstPc", outPc, 32'd0);
        expQ.delete();
        pushRange(0, 10);
        drainExpect(10, 20, cyc);
        checkOutput("throughput", 32'(cyc), 32'd10);

        // Back-pressure from a fresh reset
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", {31'b0, outValid}, 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        step();
        step();
        checkOutput("bpFirstValid", {31'b0, outValid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bpValid", {31'b0, outValid}, 32'd1);
            checkOutput("bpHeadPc", outPc, 32'd0);
            checkOutput("bpHeadInstr", outInstr, 32'h1000_0000);
            checkOutput("bpPcStall", romAddr, 32'd2);
        end
        applyStimulus(1'b1, 1'b0, '0);
        expQ.delete();
        pushRange(0, 6);
        drainExpect(6, 12, cyc);
        checkOutput("bpNoGap", 32'(cyc), 32'd6);

        // Redirect with a full queue
        applyStimulus(1'b0, 1'b0, '0);
        step();
        step();
        step();
        applyStimulus(1'b1, 1'b1, 32'd7);
        step();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("redirFlush", {31'b0, outValid}, 32'd0);
        checkOutput("redirPc", romAddr, 32'd7);
        expQ.delete();
        pushRange(7, 5);
        drainExpect(5, 10, cyc);
        checkOutput("redirBubble", 32'(cyc), 32'd6);

        // End of ROM
        applyStimulus(1'b1, 1'b1, 32'd30);
        step();
        applyStimulus(1'b1, 1'b0, '0);
        expQ.delete();
        pushRange(30, 2);
        drainExpect(2, 10, cyc);
        checkOutput("eorHalted", {31'b0, halted}, 32'd1);
        checkOutput("eorDrained", {31'b0, outValid}, 32'd0);
        checkOutput("eorPc", romAddr, 32'd32);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("haltIdle", {31'b0, outValid}, 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 32'd5);
        step();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("haltExit", {31'b0, halted}, 32'd0);
        expQ.delete();
        pushRange(5, 3);
        drainExpect(3, 10, cyc);
        applyStimulus(1'b1, 1'b1, 32'd40);
        step();
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("oorHalted", {31'b0, halted}, 32'd1);
        checkOutput("oorPc", romAddr, 32'd40);
        for (int i = 0; i < 4; i++) begin
            checkOutput("oorNoOutput", {31'b0, outValid}, 32'd0);
            step();
        end

        // Async reset while queue full and halted
        applyStimulus(1'b0, 1'b1, 32'd30);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("preRstFull", {31'b0, outValid}, 32'd1);
        checkOutput("preRstHalted", {31'b0, halted}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", {31'b0, outValid}, 32'd0);
        checkOutput("midRstHalted", {31'b0, halted}, 32'd0);
        checkOutput("midRstPc", romAddr, 32'd0);
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        step();
        checkOutput("reBootNoValid", {31'b0, outValid}, 32'd0);
        step();
        checkOutput("reFirstValid", {31'b0, outValid}, 32'd1);
        expQ.delete();
        pushRange(0, 5);
        drainExpect(5, 10, cyc);

        // Nop word at address 0
        romZero = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        expQ.delete();
`ifdef IFETCH_NOP_SQUASH_EN
        pushRange(1, 3);
`else
        pushEntry(32'd0, 32'd0);
        pushRange(1, 2);
`endif
        drainExpect(3, 12, cyc);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
